// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types for the CPU/DMA RAM arbiter
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

endpackage

// File: rtl/ram_arbiter_arb_rr2.sv
// rtl/ram_arbiter_arb_rr2.sv - two-way round-robin grant decision
module arb_rr2
    import ram_arb_pkg::*;
(
    input  logic   c_req,
    input  logic   d_req,
    input  owner_t last_owner,
    output logic   grant_valid,
    output owner_t grant_owner
);

    always_comb begin
        grant_valid = c_req | d_req;
        grant_owner = OWN_CPU;
        // On conflict the port that did not win last time goes first
        if (c_req && d_req) begin
            grant_owner = (last_owner == OWN_CPU) ? OWN_DMA : OWN_CPU;
        end else if (d_req) begin
            grant_owner = OWN_DMA;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares the single-port strobed RAM between CPU and DMA ports
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [WORD_W-1:0] c_wdata,
    output logic              c_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [WORD_W-1:0] rdata,
    output logic              owner,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WORD_W-1:0] ram_dout,
    output logic              ram_drive,
    input  logic [WORD_W-1:0] ram_din,
    output logic              RAM_NCE,
    output logic              RAM_NOE,
    output logic              RAM_NWE
);

    state_t            r_state;
    state_t            w_next;
    owner_t            r_owner;
    owner_t            r_last_owner;
    owner_t            w_grant_owner;
    logic              w_grant_valid;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic [WORD_W-1:0] r_rdata;

    arb_rr2 u_arb (
        .c_req       (c_req),
        .d_req       (d_req),
        .last_owner  (r_last_owner),
        .grant_valid (w_grant_valid),
        .grant_owner (w_grant_owner)
    );

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_state      <= IDLE;
            r_owner      <= OWN_CPU;
            r_last_owner <= OWN_DMA;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_grant_valid) begin
                r_owner <= w_grant_owner;
                if (w_grant_owner == OWN_DMA) begin
                    r_we    <= d_we;
                    r_addr  <= d_addr;
                    r_wdata <= d_wdata;
                end else begin
                    r_we    <= c_we;
                    r_addr  <= c_addr;
                    r_wdata <= c_wdata;
                end
            end
            if (r_state == ACCESS && !r_we) begin
                r_rdata <= ram_din;
            end
            if (r_state == DONE) begin
                r_last_owner <= r_owner;
            end
        end
    end

    // Strobes decode straight from the state register so reset lifts them without a clock
    always_comb begin
        w_next    = r_state;
        RAM_NCE   = 1'b1;
        RAM_NOE   = 1'b1;
        RAM_NWE   = 1'b1;
        ram_drive = 1'b0;
        c_ack     = 1'b0;
        d_ack     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_next = SETUP;
                end
            end
            SETUP: begin
                RAM_NCE = 1'b0;
                if (r_we) begin
                    ram_drive = 1'b1;
                end else begin
                    RAM_NOE = 1'b0;
                end
                w_next = ACCESS;
            end
            ACCESS: begin
                RAM_NCE = 1'b0;
                if (r_we) begin
                    RAM_NWE   = 1'b0;
                    ram_drive = 1'b1;
                end else begin
                    RAM_NOE = 1'b0;
                end
                w_next = DONE;
            end
            DONE: begin
                ram_drive = r_we;
                c_ack     = (r_owner == OWN_CPU);
                d_ack     = (r_owner == OWN_DMA);
                w_next    = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign owner    = r_owner;
    assign ram_addr = r_addr;
    assign ram_dout = r_wdata;
    assign rdata    = r_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter
module tb_ram_arbiter;

    logic       clock = 1'b0;
    logic       n_reset;
    logic       c_req, c_we, d_req, d_we;
    logic [4:0] c_addr, d_addr;
    logic [7:0] c_wdata, d_wdata;
    logic       c_ack, d_ack, owner, ram_drive;
    logic [7:0] rdata, ram_dout, ram_din;
    logic [4:0] ram_addr;
    logic       RAM_NCE, RAM_NOE, RAM_NWE;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [32];
    logic [7:0] ref_mem [32];
    logic       pl_we = 1'b0;
    logic [4:0] pl_addr = '0;
    logic [7:0] pl_data = '0;

    typedef struct packed {
        logic       cr;
        logic       cw;
        logic [4:0] ca;
        logic [7:0] cd;
        logic       dr;
        logic       dw;
        logic [4:0] da;
        logic [7:0] dd;
        logic       first;
        logic [7:0] c_rd;
        logic [7:0] d_rd;
    } vec_t;

    vec_t vecs [9];

    ram_arbiter #(.WORD_W(8), .ADDR_W(5)) dut (
        .clock     (clock),
        .n_reset   (n_reset),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_ack     (c_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .rdata     (rdata),
        .owner     (owner),
        .ram_addr  (ram_addr),
        .ram_dout  (ram_dout),
        .ram_drive (ram_drive),
        .ram_din   (ram_din),
        .RAM_NCE   (RAM_NCE),
        .RAM_NOE   (RAM_NOE),
        .RAM_NWE   (RAM_NWE)
    );

    always #5 clock = ~clock;

    // Behavioural strobed RAM: writes on a clock edge while NCE and NWE are low
    always @(posedge clock) begin
        if (pl_we) begin
            ram[pl_addr] <= pl_data;
        end else if (!RAM_NCE && !RAM_NWE && ram_drive) begin
            ram[ram_addr] <= ram_dout;
        end
    end
    assign ram_din = (!RAM_NCE && !RAM_NOE) ? ram[ram_addr] : 8'hEE;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0b required %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %02h required %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        n_reset = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clock);
        n_reset = 1'b1;
    endtask

    task automatic run_vec(input vec_t t);
        int c_at, d_at;
        c_at = t.cr ? ((t.first == 1'b0) ? 3 : 7) : 0;
        d_at = t.dr ? ((t.first == 1'b1) ? 3 : 7) : 0;
        c_req = t.cr; c_we = t.cw; c_addr = t.ca; c_wdata = t.cd;
        d_req = t.dr; d_we = t.dw; d_addr = t.da; d_wdata = t.dd;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            chk1("vec_c_ack", c_ack, i == c_at);
            chk1("vec_d_ack", d_ack, i == d_at);
            chk1("vec_noe_nwe_exclusive", RAM_NOE | RAM_NWE, 1'b1);
            if (i == 3) chk1("vec_owner", owner, t.first);
            if (i == c_at) begin
                if (!t.cw) chk8("vec_c_rdata", rdata, t.c_rd);
                c_req = 0;
            end
            if (i == d_at) begin
                if (!t.dw) chk8("vec_d_rdata", rdata, t.d_rd);
                d_req = 0;
            end
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 5'h03, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 1'b1, 5'h1F, 8'h5D, 1'b1, 8'h00, 8'h00};
        vecs[2] = '{1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 1'b0, 5'h1F, 8'h00, 1'b1, 8'h00, 8'h5D};
        vecs[3] = '{1'b1, 1'b1, 5'h0A, 8'h11, 1'b1, 1'b0, 5'h0A, 8'h00, 1'b0, 8'h00, 8'h11};
        vecs[4] = '{1'b1, 1'b0, 5'h1F, 8'h00, 1'b1, 1'b1, 5'h03, 8'h99, 1'b0, 8'h5D, 8'h00};
        vecs[5] = '{1'b1, 1'b0, 5'h03, 8'h00, 1'b1, 1'b0, 5'h0A, 8'h00, 1'b0, 8'h99, 8'h11};
        vecs[6] = '{1'b1, 1'b1, 5'h00, 8'h42, 1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 8'h00, 8'h00};
        vecs[7] = '{1'b1, 1'b0, 5'h00, 8'h00, 1'b1, 1'b1, 5'h00, 8'h7E, 1'b1, 8'h7E, 8'h00};
        vecs[8] = '{1'b1, 1'b1, 5'h05, 8'hA1, 1'b1, 1'b0, 5'h05, 8'h00, 1'b1, 8'h00, 8'h0F};

        n_reset = 1'b0;
        idle_inputs();
        for (int a = 0; a < 32; a++) begin
            @(negedge clock);
            pl_we = 1'b1;
            pl_addr = 5'(a);
            pl_data = (a == 3) ? 8'hA5 : 8'(a * 3);
        end
        @(negedge clock);
        pl_we = 1'b0;
        @(negedge clock);

        chk1("rst_nce", RAM_NCE, 1'b1);
        chk1("rst_noe", RAM_NOE, 1'b1);
        chk1("rst_nwe", RAM_NWE, 1'b1);
        chk1("rst_drive", ram_drive, 1'b0);
        chk1("rst_c_ack", c_ack, 1'b0);
        chk1("rst_d_ack", d_ack, 1'b0);
        chk1("rst_owner", owner, 1'b0);
        chk8("rst_rdata", rdata, 8'h00);
        chk8("rst_ram_addr", {3'b000, ram_addr}, 8'h00);
        chk8("rst_ram_dout", ram_dout, 8'h00);
        n_reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk1("idle_nce", RAM_NCE, 1'b1);
            chk1("idle_drive", ram_drive, 1'b0);
            chk1("idle_c_ack", c_ack | d_ack, 1'b0);
        end

        // CPU read of 5'h03
        c_req = 1; c_we = 0; c_addr = 5'h03;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            chk1("cr_nce", RAM_NCE, i == 3);
            chk1("cr_noe", RAM_NOE, i == 3);
            chk1("cr_nwe", RAM_NWE, 1'b1);
            chk1("cr_drive", ram_drive, 1'b0);
            chk1("cr_c_ack", c_ack, i == 3);
            chk8("cr_ram_addr", {3'b000, ram_addr}, 8'h03);
        end
        chk8("cr_rdata", rdata, 8'hA5);
        c_req = 0;
        @(negedge clock);

        // DMA write of 8'h3C to 5'h1F
        d_req = 1; d_we = 1; d_addr = 5'h1F; d_wdata = 8'h3C;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            chk1("dw_nwe", RAM_NWE, i != 2);
            chk1("dw_noe", RAM_NOE, 1'b1);
            chk1("dw_drive", ram_drive, 1'b1);
            chk1("dw_d_ack", d_ack, i == 3);
            chk8("dw_ram_addr", {3'b000, ram_addr}, 8'h1F);
        end
        chk8("dw_ram_content", ram[5'h1F], 8'h3C);
        chk1("dw_owner", owner, 1'b1);
        chk8("dw_rdata_kept", rdata, 8'hA5);
        d_req = 0;
        @(negedge clock);
        chk1("dw_drive_release", ram_drive, 1'b0);

        for (int v = 0; v < 9; v++) run_vec(vecs[v]);

        // Reset during ACCESS of a CPU write
        c_req = 1; c_we = 1; c_addr = 5'h07; c_wdata = 8'hBB;
        repeat (2) @(negedge clock);
        chk1("abort_nwe_low", RAM_NWE, 1'b0);
        #2 n_reset = 1'b0;
        #1;
        chk1("abort_nwe_async", RAM_NWE, 1'b1);
        chk1("abort_nce_async", RAM_NCE, 1'b1);
        chk1("abort_drive_async", ram_drive, 1'b0);
        c_req = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk1("abort_no_ack", c_ack, 1'b0);
        end
        n_reset = 1'b1;

        // Held contention right after reset: C, D, C, D
        c_req = 1; c_we = 0; c_addr = 5'h03;
        d_req = 1; d_we = 0; d_addr = 5'h0A;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clock);
            chk1("cont_c_ack", c_ack, i == 3 || i == 11);
            chk1("cont_d_ack", d_ack, i == 7 || i == 15);
        end
        idle_inputs();
        @(negedge clock);

        // CPU alone, back-to-back
        c_req = 1; c_we = 0; c_addr = 5'h0A;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            chk1("busy_c_ack", c_ack, i == 3 || i == 7 || i == 11);
            chk1("busy_owner", owner, 1'b0);
        end
        idle_inputs();

        // Randomised traffic against a transaction-level model
        do_reset();
        for (int a = 0; a < 32; a++) ref_mem[a] = ram[a];
        begin
            int       next_free, ack_cyc;
            bit       ack_pend, ack_own, ack_we, m_owner, m_last, c_act, d_act, pick;
            bit       exp_c, exp_d;
            bit [4:0] ack_addr;
            bit [7:0] ack_wdata;
            next_free = 0; ack_cyc = 0; ack_pend = 0; ack_own = 0; ack_we = 0;
            ack_addr = '0; ack_wdata = '0;
            m_owner = 0; m_last = 1; c_act = 0; d_act = 0;
            for (int k = 0; k < 600; k++) begin
                if (k > 0) begin
                    @(negedge clock);
                    exp_c = ack_pend && ack_cyc == k && !ack_own;
                    exp_d = ack_pend && ack_cyc == k && ack_own;
                    chk1("rnd_c_ack", c_ack, exp_c);
                    chk1("rnd_d_ack", d_ack, exp_d);
                    chk1("rnd_owner", owner, m_owner);
                    chk1("rnd_noe_nwe_exclusive", RAM_NOE | RAM_NWE, 1'b1);
                    if (exp_c || exp_d) begin
                        if (ack_we) begin
                            ref_mem[ack_addr] = ack_wdata;
                            chk8("rnd_ram_write", ram[ack_addr], ack_wdata);
                        end else begin
                            chk8("rnd_rdata", rdata, ref_mem[ack_addr]);
                        end
                        if (ack_own) begin d_act = 0; d_req = 0; end
                        else begin c_act = 0; c_req = 0; end
                        ack_pend = 0;
                    end
                end
                if (!c_act && $urandom_range(2, 0) != 0) begin
                    c_act = 1; c_req = 1; c_we = 1'($urandom);
                    c_addr = 5'($urandom); c_wdata = 8'($urandom);
                end
                if (!d_act && $urandom_range(2, 0) != 0) begin
                    d_act = 1; d_req = 1; d_we = 1'($urandom);
                    d_addr = 5'($urandom); d_wdata = 8'($urandom);
                end
                if (k >= next_free && (c_act || d_act)) begin
                    pick      = (c_act && d_act) ? !m_last : d_act;
                    ack_own   = pick;
                    ack_we    = pick ? d_we : c_we;
                    ack_addr  = pick ? d_addr : c_addr;
                    ack_wdata = pick ? d_wdata : c_wdata;
                    m_owner   = pick;
                    m_last    = pick;
                    ack_pend  = 1;
                    ack_cyc   = k + 3;
                    next_free = k + 4;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port, active-low-strobed program/data RAM between two requesters: the CPU sequencer (port C) and a DMA/display-scan engine (port D).
- Each requester presents a request with address, write flag and write data, then waits for a one-cycle ack.
- The arbiter owns the RAM address, data-out, tri-state enable and NCE/NOE/NWE pins.
- Sits between the processor datapath/sequencer, the DMA engine and the RAM.

Parameters:
- WORD_W, 8: data word width.
- ADDR_W, 5: RAM address width.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- c_req  in  1  CPU access request; level-held until c_ack is seen.
- c_we  in  1  CPU access type: 1 = write, 0 = read.
- c_addr  in  ADDR_W  CPU address.
- c_wdata  in  WORD_W  CPU write data.
- c_ack  out  1  one-cycle completion pulse to the CPU.
- d_req, d_we, d_addr, d_wdata, d_ack  same widths and meanings as the C port, for the DMA requester.
- rdata  out  WORD_W  read data; valid in the ack cycle and held until the next read completes.
- owner  out  1  current or last grantee: 0 = CPU, 1 = DMA.
- ram_addr  out  ADDR_W  RAM address.
- ram_dout  out  WORD_W  write data to the RAM data bus.
- ram_drive  out  1  tri-state enable for ram_dout.
- ram_din  in  WORD_W  data from the RAM.
- RAM_NCE, RAM_NOE, RAM_NWE  out  1  RAM chip enable, output enable and write enable, all active-low.

Behaviour:
- Reset values:
  - RAM_NCE, RAM_NOE and RAM_NWE = 1.
  - ram_drive, c_ack, d_ack = 0.
  - ram_addr, ram_dout, rdata = 0.
  - owner = 0; state = IDLE; last_owner = DMA, so the CPU wins the first conflict.
- FSM states: IDLE, SETUP, ACCESS, DONE. Every transition is unconditional except the one leaving IDLE.
- IDLE:
  - All strobes are 1 and both acks are 0.
  - If neither request is set, stay in IDLE.
  - If exactly one request is set, grant it.
  - If both are set, grant the requester that is not last_owner (2-way round robin).
  - On a grant, register owner, we, addr and wdata from the granted port, then go to SETUP.
- SETUP:
  - ram_addr is driven from the registered address.
  - Read: NCE = 0, NOE = 0.
  - Write: NCE = 0, ram_drive = 1, NOE = 1, NWE = 1.
  - Next state is ACCESS.
- ACCESS:
  - Read: NCE = 0 and NOE = 0; rdata captures ram_din on the closing edge.
  - Write: NCE = 0, NWE = 0 and ram_drive = 1.
  - Next state is DONE.
- DONE:
  - NCE, NOE and NWE return to 1.
  - ram_drive stays at 1 for writes, giving data hold after NWE rises.
  - The owner's ack is 1 for this cycle only; last_owner is updated to owner.
  - Next state is IDLE.
- Timing guarantees:
  - NWE is low for exactly one cycle, and only in ACCESS.
  - ram_addr is stable from SETUP through DONE; NOE and NWE are never low together.
- Latency: a request seen in IDLE at cycle t produces its ack at t+3. An access occupies 4 cycles.
- Handshake:
  - A requester holds req, we, addr and wdata stable from assertion until the ack.
  - It deasserts req on the edge where it samples ack.
  - A req still high in the following IDLE cycle is a new request.
  - The non-granted request stays pending with no timeout.
- Fairness: with both ports requesting continuously, grants alternate C, D, C, D. The worst-case wait is one access, i.e. 4 cycles.
- Reset mid-operation:
  - Asserting n_reset forces the reset values immediately (asynchronously); NWE rises without waiting for a clock.
  - The in-flight access is abandoned and no ack is issued.
  - A write interrupted mid-ACCESS leaves the RAM content undefined. The requester re-issues after reset.
- rdata is not altered by write accesses.

Decomposition:
- Package ram_arb_pkg:
  - typedef enum of the FSM states {IDLE, SETUP, ACCESS, DONE}.
  - typedef enum owner_t {OWN_CPU = 0, OWN_DMA = 1}.
- One combinational sub-module, arb_rr2:
  - Inputs: c_req, d_req, last_owner.
  - Outputs: grant_valid and grant_owner.
- Everything else (FSM, port mux, registers) lives in ram_arbiter.

Test Plan:
- Reset: drive n_reset = 0 for 2 cycles, then release with no requests -> strobes = 1, ram_drive = 0, acks = 0, state remains IDLE.
- CPU read: RAM model holds 8'hA5 at 5'h03; c_req with c_we = 0 and c_addr = 5'h03 at t -> NCE and NOE = 0 in t+1 and t+2, c_ack = 1 at t+3, rdata = 8'hA5.
- DMA write: d_addr = 5'h1F, d_wdata = 8'h3C -> NWE = 0 only at t+2, ram_drive = 1 from t+1 to t+3, d_ack at t+3, RAM model holds 8'h3C at 5'h1F.
- Contention: c_req and d_req asserted together from reset, each held (re-asserted after its ack) -> ack order C, D, C, D with one ack every 4 cycles.
- Single busy port: CPU requests back-to-back with d_req = 0 -> consecutive c_ack pulses 4 cycles apart; owner stays 0.
- Reset abort: n_reset = 0 during ACCESS of a CPU write -> NWE = 1 asynchronously, no c_ack; after release, a c_req/d_req conflict is granted to the CPU first.
